ex_operand_stage: RTL

- ID/EX pipeline register plus EX-side operand logic for the RV32I pipeline.
- Latches decoded instruction fields and decodes funct3/funct7 into the 4-bit ALU opcode.
- Resolves forwarding from EX/MEM and MEM/WB, then drives the ALU's A, B and AluOp inputs.
- Detects load-use hazards and inserts bubbles on stall, flush or hazard.

---
 rtl/ex_operand_stage.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX pipeline register with ALU opcode decode, forwarding and load-use detection
//
// Purpose:
//   Captures the decoded instruction from ID.
//   Translates funct3/funct7 into the 4-bit ALU opcode.
//   Resolves EX/MEM and MEM/WB forwarding for both source operands.
//   Presents the ALU inputs alu_a, alu_b and alu_op.
//   Raises load_use_hazard so the front end can hold IF/ID.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   stall               hold every stage register
//   flush               load a bubble instead of the ID instruction
//   id_*                decoded instruction fields and control from ID
//   exm_*               EX/MEM destination, write enable and result (forwarding source)
//   wb_*                MEM/WB destination, write enable and value (forwarding source)
//   alu_a, alu_b        ALU operands
//   alu_op              ALU opcode
//   ex_valid, ex_rd     EX slot valid flag and destination register
//   ex_reg_write,
//   ex_mem_read,
//   ex_mem_write        latched control bits, gated by ex_valid
//   ex_store_data       forwarded rs2 value, used as the store data
//   load_use_hazard     load in EX feeds the instruction in ID; hold IF/ID

module ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7_5,
    input  logic [1:0]      id_op_class,
    input  logic            id_use_imm,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic [RA_W-1:0] exm_rd,
    input  logic            exm_reg_write,
    input  logic [XLEN-1:0] exm_result,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    output logic            ex_valid,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic [XLEN-1:0] ex_store_data,
    output logic            load_use_hazard
);

    // ALU opcode encodings
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SRA = 4'b1000;
    localparam logic [3:0] OP_XOR = 4'b1100;
    localparam logic [3:0] OP_SLL = 4'b1101;
    localparam logic [3:0] OP_SRL = 4'b1110;

    // Instruction classes
    localparam logic [1:0] CLS_LDST   = 2'b00;
    localparam logic [1:0] CLS_BRANCH = 2'b01;
    localparam logic [1:0] CLS_RTYPE  = 2'b10;

    // Stage registers
    logic            valid_q,     valid_d;
    logic [XLEN-1:0] rs1_data_q,  rs1_data_d;
    logic [XLEN-1:0] rs2_data_q,  rs2_data_d;
    logic [XLEN-1:0] imm_q,       imm_d;
    logic [RA_W-1:0] rs1_q,       rs1_d;
    logic [RA_W-1:0] rs2_q,       rs2_d;
    logic [RA_W-1:0] rd_q,        rd_d;
    logic [3:0]      alu_op_q,    alu_op_d;
    logic            use_imm_q,   use_imm_d;
    logic            reg_write_q, reg_write_d;
    logic            mem_read_q,  mem_read_d;
    logic            mem_write_q, mem_write_d;

    logic [3:0]      op_dec;
    logic            hazard;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic [XLEN-1:0] b_sel;
    logic            is_shift;

    // ------------------------------------------------------------------
    // Opcode decode of the incoming ID instruction
    // ------------------------------------------------------------------
    always_comb begin
        op_dec = OP_ADD;
        case (id_op_class)
            CLS_LDST:   op_dec = OP_ADD;
            CLS_BRANCH: op_dec = OP_SUB;
            default: begin
                // R-type and I-type ALU share the funct3 table.
                // Only R-type can turn ADD into SUB.
                // funct7_5 selects SRA for both R-type and I-type shifts.
                case (id_funct3)
                    3'b000: op_dec = (id_op_class == CLS_RTYPE && id_funct7_5) ? OP_SUB : OP_ADD;
                    3'b001: op_dec = OP_SLL;
                    3'b010: op_dec = OP_SLT;
                    3'b011: op_dec = OP_SLT;
                    3'b100: op_dec = OP_XOR;
                    3'b101: op_dec = id_funct7_5 ? OP_SRA : OP_SRL;
                    3'b110: op_dec = OP_OR;
                    3'b111: op_dec = OP_AND;
                    default: op_dec = OP_ADD;
                endcase
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load-use hazard.
    // rs2 is compared even for instructions that do not read it; this
    // over-stalls occasionally but needs no knowledge of the instruction format.
    // The hazard is suppressed during stall, because the EX slot is frozen anyway.
    // ------------------------------------------------------------------
    always_comb begin
        hazard = 1'b0;
        if (!stall && id_valid && valid_q && mem_read_q && (rd_q != '0)) begin
            hazard = (rd_q == id_rs1) || (rd_q == id_rs2);
        end
    end

    assign load_use_hazard = hazard;

    // ------------------------------------------------------------------
    // Next-state selection: stall > flush > hazard > load
    // ------------------------------------------------------------------
    always_comb begin
        valid_d     = valid_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        alu_op_d    = alu_op_q;
        use_imm_d   = use_imm_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;

        if (!stall) begin
            if (flush || hazard) begin
                valid_d     = 1'b0;
                rs1_data_d  = '0;
                rs2_data_d  = '0;
                imm_d       = '0;
                rs1_d       = '0;
                rs2_d       = '0;
                rd_d        = '0;
                alu_op_d    = OP_AND;
                use_imm_d   = 1'b0;
                reg_write_d = 1'b0;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end else begin
                valid_d     = id_valid;
                rs1_data_d  = id_rs1_data;
                rs2_data_d  = id_rs2_data;
                imm_d       = id_imm;
                rs1_d       = id_rs1;
                rs2_d       = id_rs2;
                rd_d        = id_rd;
                alu_op_d    = op_dec;
                use_imm_d   = id_use_imm;
                // Writes to x0 are dropped here so later stages never forward them.
                reg_write_d = id_valid && id_reg_write && (id_rd != '0);
                mem_read_d  = id_valid && id_mem_read;
                mem_write_d = id_valid && id_mem_write;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            alu_op_q    <= OP_AND;
            use_imm_q   <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            alu_op_q    <= alu_op_d;
            use_imm_q   <= use_imm_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding.
    // EX/MEM is the younger producer, so it is checked first.
    // x0 never forwards.
    // ------------------------------------------------------------------
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (rs1_q != '0) begin
            if (exm_reg_write && (exm_rd == rs1_q)) begin
                fwd_rs1 = exm_result;
            end else if (wb_reg_write && (wb_rd == rs1_q)) begin
                fwd_rs1 = wb_result;
            end
        end
    end

    always_comb begin
        fwd_rs2 = rs2_data_q;
        if (rs2_q != '0) begin
            if (exm_reg_write && (exm_rd == rs2_q)) begin
                fwd_rs2 = exm_result;
            end else if (wb_reg_write && (wb_rd == rs2_q)) begin
                fwd_rs2 = wb_result;
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand muxes.
    // Shifts use only shamt, so the upper bits of alu_b are cleared.
    // For immediates this removes the funct7 bits that share the encoding.
    // ------------------------------------------------------------------
    always_comb begin
        is_shift = (alu_op_q == OP_SLL) || (alu_op_q == OP_SRL) || (alu_op_q == OP_SRA);
        b_sel    = use_imm_q ? imm_q : fwd_rs2;
        alu_b    = b_sel;
        if (is_shift) begin
            alu_b = {{(XLEN-5){1'b0}}, b_sel[4:0]};
        end
    end

    assign alu_a         = fwd_rs1;
    assign alu_op        = alu_op_q;
    assign ex_store_data = fwd_rs2;
    assign ex_valid      = valid_q;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = valid_q & reg_write_q;
    assign ex_mem_read   = valid_q & mem_read_q;
    assign ex_mem_write  = valid_q & mem_write_q;

endmodule
